// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and constants for the motor PWM driver.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int DUTY_W = 8;

  // Highest pwm_cnt value; a duty of 255 therefore never drops low.
  localparam logic [DUTY_W-1:0] PWM_MAX = 8'd254;

  // 100 MHz / 392 / 255 gives roughly a 1 kHz PWM period.
  localparam int PRESCALE_DEF     = 392;
  localparam int DEAD_PERIODS_DEF = 2;

endpackage

// File: rtl/motor_pwm_driver_timebase.sv
// PWM timebase: prescaler and 0..254 period counter with synchronous clear.
module pwm_timebase
  import motor_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              tick,
  output logic              wrap,
  output logic [DUTY_W-1:0] pwm_cnt
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc;

  // A cleared timebase never ticks, so nothing downstream sees a stray wrap.
  assign tick = !clr && (presc == PS_LAST);
  assign wrap = tick && (pwm_cnt == PWM_MAX);

  // Prescaler and period counter; held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      presc   <= '0;
      pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver with dead-time on every direction reversal.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESCALE     = PRESCALE_DEF,
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dir,
  input  logic [DUTY_W-1:0] duty,
  output logic              en_a,
  output logic              en_b,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              in4,
  output logic              busy,
  output logic              period_start
);

  localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

  state_t            state, state_next;
  logic              tick, wrap;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_buf;
  logic              dir_applied;
  logic [DEAD_W-1:0] dead_cnt;
  logic              pwm_raw;
  logic              load_entry, dir_load, dead_clr, dead_inc;

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .tick   (tick),
    .wrap   (wrap),
    .pwm_cnt(pwm_cnt)
  );

  // pwm_cnt tops out at 254, so a buffered duty of 255 is a steady high.
  assign pwm_raw = (pwm_cnt < duty_buf);

  // Next-state logic; dropping enable beats any pending direction change.
  always_comb begin
    state_next = state;
    load_entry = 1'b0;
    dir_load   = 1'b0;
    dead_clr   = 1'b0;
    dead_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
          load_entry = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (dir != dir_applied) begin
          state_next = DEAD;
          dead_clr   = 1'b1;
        end
      end
      DEAD: begin
        // Further dir toggles are ignored here; dir is only sampled on exit.
        if (!enable) begin
          state_next = IDLE;
        end else if (wrap) begin
          if (dead_cnt == DEAD_LAST) begin
            state_next = RUN;
            dir_load   = 1'b1;
          end else begin
            dead_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Duty buffer, applied direction and dead-time counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_buf    <= '0;
      dir_applied <= 1'b0;
      dead_cnt    <= '0;
    end else begin
      if (load_entry) begin
        duty_buf    <= duty;
        dir_applied <= dir;
      end else if (wrap) begin
        duty_buf <= duty;
      end
      if (dir_load) begin
        dir_applied <= dir;
      end
      if (dead_clr) begin
        dead_cnt <= '0;
      end else if (dead_inc) begin
        dead_cnt <= dead_cnt + 1'b1;
      end
    end
  end

  // Registered bridge outputs, one clk behind the internal state.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_a         <= 1'b0;
      en_b         <= 1'b0;
      in1          <= 1'b0;
      in2          <= 1'b0;
      in3          <= 1'b0;
      in4          <= 1'b0;
      busy         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      en_a         <= 1'b0;
      en_b         <= 1'b0;
      in1          <= 1'b0;
      in2          <= 1'b0;
      in3          <= 1'b0;
      in4          <= 1'b0;
      busy         <= 1'b0;
      period_start <= wrap && (state != IDLE);
      case (state)
        RUN: begin
          en_a <= pwm_raw;
          en_b <= pwm_raw;
          in1  <= ~dir_applied;
          in2  <= dir_applied;
          in3  <= ~dir_applied;
          in4  <= dir_applied;
        end
        DEAD: busy <= 1'b1;
        default: ;
      endcase
    end
  end

  // Never shoot through a leg, and never swap a leg without an off cycle.
  a_no_shoot: assert property (@(posedge clk) disable iff (rst)
    !((in1 && in2) || (in3 && in4)));
  a_no_swap: assert property (@(posedge clk) disable iff (rst)
    !(($past(in1) && in2) || ($past(in2) && in1) ||
      ($past(in3) && in4) || ($past(in4) && in3)));
  a_wrap_on_tick: assert property (@(posedge clk) disable iff (rst)
    wrap |-> tick);

endmodule
